// File: rtl/conv2d_seq_engine.sv
// rtl/conv2d_seq_engine.sv - sequential KxK valid-mode convolution, NF filters, one output position per clock
// Captures image/filters at start, then streams positions in raster order into out_img and pix_*.
module conv2d_seq_engine #(
  parameter int N     = 12,
  parameter int K     = 3,
  parameter int DW    = 2,
  parameter int WW    = 2,
  parameter int NF    = 2,
  parameter int SHIFT = 0,
  localparam int M    = N - K + 1,
  localparam int RW   = (M > 1) ? $clog2(M) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   relu_en,
  input  logic [N*N*DW-1:0]      in_img,
  input  logic [NF*K*K*WW-1:0]   filters,
  output logic                   busy,
  output logic                   done,
  output logic [NF*M*M*DW-1:0]   out_img,
  output logic                   pix_valid,
  output logic [RW-1:0]          pix_row,
  output logic [RW-1:0]          pix_col,
  output logic [NF*DW-1:0]       pix_data
);

  localparam int AW = DW + WW + $clog2(K*K) + 1;
  localparam logic signed [AW-1:0] L_UMAX = AW'((2**DW) - 1);
  localparam logic signed [AW-1:0] L_SMAX = AW'((2**(DW-1)) - 1);
  localparam logic signed [AW-1:0] L_SMIN = AW'(-(2**(DW-1)));
  localparam logic [RW-1:0]        L_LAST = RW'(M - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [N*N*DW-1:0]       r_img;
  logic [NF*K*K*WW-1:0]    r_flt;
  logic                    r_relu;
  logic [RW-1:0]           r_row;
  logic [RW-1:0]           r_col;
  logic                    r_done;
  logic [NF*M*M*DW-1:0]    r_out;
  logic                    r_pix_valid;
  logic [RW-1:0]           r_pix_row;
  logic [RW-1:0]           r_pix_col;
  logic [NF*DW-1:0]        r_pix_data;

  logic                    w_last;
  logic signed [AW-1:0]    w_acc;
  logic signed [AW-1:0]    w_s;
  logic signed [AW-1:0]    w_pix;
  logic signed [AW-1:0]    w_wt;
  logic [NF*DW-1:0]        w_res;

  assign w_last = (r_row == L_LAST) && (r_col == L_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pixels are zero-extended and weights sign-extended to AW so the MAC is exact.
  always_comb begin
    w_res = '0;
    w_acc = '0;
    w_s   = '0;
    w_pix = '0;
    w_wt  = '0;
    for (int f = 0; f < NF; f++) begin
      w_acc = '0;
      for (int ki = 0; ki < K; ki++) begin
        for (int kj = 0; kj < K; kj++) begin
          w_pix = AW'({1'b0, r_img[((int'(r_row) + ki) * N + int'(r_col) + kj) * DW +: DW]});
          w_wt  = AW'($signed(r_flt[(f*K*K + ki*K + kj) * WW +: WW]));
          w_acc = w_acc + w_pix * w_wt;
        end
      end
      w_s = w_acc >>> SHIFT;
      if (r_relu) begin
        if (w_s[AW-1])        w_res[f*DW +: DW] = '0;
        else if (w_s > L_UMAX) w_res[f*DW +: DW] = '1;
        else                   w_res[f*DW +: DW] = w_s[DW-1:0];
      end else begin
        if (w_s > L_SMAX)      w_res[f*DW +: DW] = L_SMAX[DW-1:0];
        else if (w_s < L_SMIN) w_res[f*DW +: DW] = L_SMIN[DW-1:0];
        else                   w_res[f*DW +: DW] = w_s[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row       <= '0;
      r_col       <= '0;
      r_done      <= 1'b0;
      r_out       <= '0;
      r_pix_valid <= 1'b0;
      r_pix_row   <= '0;
      r_pix_col   <= '0;
      r_pix_data  <= '0;
    end else begin
      r_done      <= 1'b0;
      r_pix_valid <= 1'b0;
      if (r_state == IDLE && start) begin
        r_img  <= in_img;
        r_flt  <= filters;
        r_relu <= relu_en;
        r_out  <= '0;
        r_row  <= '0;
        r_col  <= '0;
      end else if (r_state == RUN) begin
        for (int f = 0; f < NF; f++)
          r_out[(f*M*M + int'(r_row)*M + int'(r_col)) * DW +: DW] <= w_res[f*DW +: DW];
        r_pix_valid <= 1'b1;
        r_pix_row   <= r_row;
        r_pix_col   <= r_col;
        r_pix_data  <= w_res;
        if (w_last) begin
          r_done <= 1'b1;
        end else if (r_col == L_LAST) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + RW'(1);
        end
      end
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = r_done;
  assign out_img   = r_out;
  assign pix_valid = r_pix_valid;
  assign pix_row   = r_pix_row;
  assign pix_col   = r_pix_col;
  assign pix_data  = r_pix_data;

endmodule

// File: tb/tb_conv2d_seq_engine.sv
// tb/tb_conv2d_seq_engine.sv - scoreboard bench for conv2d_seq_engine (default and N=4/SHIFT=1 instances)
module tb_conv2d_seq_engine;
  localparam int N = 12, K = 3, DW = 2, WW = 2, NF = 2, M = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, start, relu_en;
  logic [N*N*DW-1:0]     in_img;
  logic [NF*K*K*WW-1:0]  filters;
  logic                  busy, done, pix_valid;
  logic [NF*M*M*DW-1:0]  out_img;
  logic [3:0]            pix_row, pix_col;
  logic [NF*DW-1:0]      pix_data;

  logic                  b_start, b_relu, b_busy, b_done, b_pix_valid;
  logic [31:0]           b_in;
  logic [35:0]           b_filt;
  logic [15:0]           b_out;
  logic                  b_row, b_col;
  logic [3:0]            b_data;

  conv2d_seq_engine dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .in_img(in_img), .filters(filters),
    .busy(busy), .done(done), .out_img(out_img), .pix_valid(pix_valid),
    .pix_row(pix_row), .pix_col(pix_col), .pix_data(pix_data));

  conv2d_seq_engine #(.N(4), .K(3), .SHIFT(1)) dut4 (
    .clk(clk), .rst(rst), .start(b_start), .relu_en(b_relu), .in_img(b_in), .filters(b_filt),
    .busy(b_busy), .done(b_done), .out_img(b_out), .pix_valid(b_pix_valid),
    .pix_row(b_row), .pix_col(b_col), .pix_data(b_data));

  int n_cmp = 0, n_err = 0, pv_cnt = 0, b_pv_cnt = 0;
  logic [11:0] exp_q[$];
  logic [5:0]  b_q[$];
  logic [11:0] e;
  logic [5:0]  be;

  task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pix_valid) begin
      pv_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pix_unexpected: got %h expected none", {pix_row, pix_col, pix_data});
      end else begin
        e = exp_q.pop_front();
        check("pix", 400'({pix_row, pix_col, pix_data}), 400'(e));
      end
    end
    if (b_pix_valid) begin
      b_pv_cnt++;
      if (b_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pix4_unexpected: got %h expected none", {b_row, b_col, b_data});
      end else begin
        be = b_q.pop_front();
        check("pix4", 400'({b_row, b_col, b_data}), 400'(be));
      end
    end
  end

  task automatic push_const(input logic [3:0] d);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++)
        exp_q.push_back({4'(r), 4'(c), d});
  endtask

  task automatic push_center(input logic [N*N*DW-1:0] im);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++)
        exp_q.push_back({4'(r), 4'(c), 2'b00, im[((r+1)*N + c + 1)*DW +: DW]});
  endtask

  function automatic logic [399:0] center_out(input logic [N*N*DW-1:0] im);
    logic [399:0] o;
    o = '0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++)
        o[(r*M + c)*DW +: DW] = im[((r+1)*N + c + 1)*DW +: DW];
    return o;
  endfunction

  // Issued between edges; returns #1 after the start edge.
  task automatic fire(input logic relu);
    start = 1'b1;
    relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int pa, input int pb, input int chg, output int lat, output int bcnt);
    bcnt = busy ? 1 : 0;
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == pa || lat == pb);
      if (lat == chg) in_img = ~in_img;
      if (done) break;
      if (busy) bcnt++;
      if (lat >= 300) begin
        n_cmp++; n_err++;
        $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
        break;
      end
    end
    start = 1'b0;
  endtask

  logic [N*N*DW-1:0] img, img2;
  int lat, bc;
  logic dseen;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; in_img = '0; filters = '0;
    b_start = 1'b0; b_relu = 1'b0; b_in = '0; b_filt = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ctl", 400'({busy, done, pix_valid, pix_row, pix_col, pix_data}), 400'(0));
    check("reset_out", out_img, 400'(0));

    // all ones image, filter0 = +1, filter1 = -1, ReLU
    @(negedge clk);
    in_img  = {144{2'b01}};
    filters = {{9{2'b11}}, {9{2'b01}}};
    push_const(4'b0011);
    pv_cnt = 0;
    fire(1'b1);
    wait_done(0, 0, 0, lat, bc);
    check("t1_latency", 400'(lat), 400'(100));
    check("t1_out", out_img, {{100{2'b00}}, {100{2'b11}}});
    @(posedge clk); #1;
    check("t1_done_pulse", 400'({done, busy}), 400'(0));
    check("t1_pix_count", 400'(pv_cnt), 400'(100));

    // same stimulus, signed clamp
    push_const(4'b1001);
    fire(1'b0);
    wait_done(0, 0, 0, lat, bc);
    check("t2_latency", 400'(lat), 400'(100));
    check("t2_busy_cycles", 400'(bc), 400'(100));
    check("t2_out", out_img, {{100{2'b10}}, {100{2'b01}}});

    // centre-tap identity filter on a random image
    for (int i = 0; i < N*N; i++) img[i*DW +: DW] = 2'($urandom_range(0, 3));
    in_img = img;
    filters = '0;
    filters[9:8] = 2'b01;
    push_center(img);
    fire(1'b1);
    wait_done(0, 0, 0, lat, bc);
    check("t3_latency", 400'(lat), 400'(100));
    check("t3_out", out_img, center_out(img));

    // restart attempts and input changes mid-run are ignored
    @(posedge clk); #1;
    push_center(img);
    fire(1'b1);
    wait_done(5, 50, 20, lat, bc);
    check("t4_latency", 400'(lat), 400'(100));
    check("t4_out", out_img, center_out(img));
    // start issued during the done cycle
    for (int i = 0; i < N*N; i++) img2[i*DW +: DW] = 2'($urandom_range(0, 3));
    in_img = img2;
    push_center(img2);
    fire(1'b1);
    check("t4_restart", 400'({busy, done}), 400'(2'b10));
    wait_done(0, 0, 0, lat, bc);
    check("t4b_latency", 400'(lat), 400'(100));
    check("t4b_out", out_img, center_out(img2));

    // reset mid-run
    @(posedge clk); #1;
    in_img  = {144{2'b01}};
    filters = {{9{2'b11}}, {9{2'b01}}};
    push_const(4'b0011);
    fire(1'b1);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_after_rst", 400'({busy, pix_valid, done}), 400'(0));
    check("t5_out_cleared", out_img, 400'(0));
    exp_q.delete();
    dseen = 1'b0;
    repeat (120) begin
      @(posedge clk); #1;
      dseen = dseen | done;
    end
    check("t5_no_done", 400'(dseen), 400'(0));
    push_const(4'b0011);
    fire(1'b1);
    wait_done(0, 0, 0, lat, bc);
    check("t5_latency", 400'(lat), 400'(100));
    check("t5_out", out_img, {{100{2'b00}}, {100{2'b11}}});

    // N=4, SHIFT=1 instance: acc 27 -> 13 -> saturates to 3
    b_in = {16{2'b11}};
    b_filt = {18{2'b01}};
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        b_q.push_back({1'(r), 1'(c), 4'b1111});
    b_pv_cnt = 0;
    b_start = 1'b1; b_relu = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (b_done) break;
    end
    check("t6_latency", 400'(lat), 400'(4));
    check("t6_out", 400'(b_out), 400'(16'hFFFF));
    @(posedge clk); #1;
    check("t6_pix_count", 400'(b_pv_cnt), 400'(4));
    check("queues_drained", 400'(exp_q.size() + b_q.size()), 400'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv2d_seq_engine.md
Name: conv2d_seq_engine

Overview:
- Parametrised, sequential successor to the fixed 12x12 / 10x10 combinational convolution PEs.
- Computes a valid-mode KxK convolution of one NxN image against NF filters in parallel.
- Produces one output position per clock for all filters, in raster order.
- Adds a start/busy/done handshake, per-pixel streaming output, shift/saturation scaling and a selectable ReLU mode. Instances cascade to build multi-layer networks.

Parameters:
- N, 12, input image side length (pixels)
- K, 3, kernel side length; M = N-K+1 is the output side
- DW, 2, pixel width (input and output)
- WW, 2, weight width, signed two's complement
- NF, 2, number of filters computed in parallel
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
- clk  input  1  clock; all logic rising-edge
- rst  input  1  synchronous active-high reset
- start  input  1  request a run; accepted only when busy=0
- relu_en  input  1  output mode select, sampled with start
- in_img  input  N*N*DW  pixel (i,j) at bits [(i*N+j)*DW +: DW], unsigned
- filters  input  NF*K*K*WW  weight (f,ki,kj) at bits [(f*K*K+ki*K+kj)*WW +: WW], signed
- busy  output  1  run in progress
- done  output  1  one-cycle pulse after the last position is written
- out_img  output  NF*M*M*DW  result (f,r,c) at bits [(f*M*M+r*M+c)*DW +: DW]
- pix_valid  output  1  pix_* fields valid this cycle
- pix_row  output  clog2(M)  row of the streamed position
- pix_col  output  clog2(M)  column of the streamed position
- pix_data  output  NF*DW  filter f result at bits [f*DW +: DW]

Behaviour:
- Reset (rst=1 at an edge): state IDLE; busy=0, done=0, pix_valid=0, pix_row=0, pix_col=0, pix_data=0, out_img=0. Reset during a run aborts it; no done pulse is issued.
- States are IDLE and RUN.
- IDLE -> RUN at the edge where start=1 (edge t0). At that edge:
  - in_img, filters and relu_en are captured into internal registers. Inputs may change freely afterwards.
  - out_img is cleared to 0.
  - The row/col counters are set to 0.
  - busy goes to 1.
- RUN: at edges t0+1 .. t0+M*M, position p=r*M+c is computed from the captured data and written into out_img. Counters advance column first, then row; col wraps M-1 -> 0 and increments row.
- At edge t0+M*M: state -> IDLE, busy=0, done=1 for exactly one cycle. Latency from the start edge to done high is M*M edges (100 for defaults).
- start while busy=1 is ignored. start in the cycle where done=1 is accepted, since busy is already 0.
- Streaming: pix_valid=1 during the cycle following each position write. pix_row, pix_col and pix_data equal that position's values and match out_img. pix_valid is otherwise 0.
- Arithmetic per filter:
  - acc = sum over ki,kj of zero-extended pixel(r+ki, c+kj) times the signed weight.
  - Accumulator width is DW+WW+clog2(K*K)+1, so it never overflows.
  - s = acc >>> SHIFT (arithmetic shift).
- Output mode relu_en=1: result = 0 if s<0, else min(s, 2^DW-1), unsigned.
- Output mode relu_en=0: result = s clamped to [-2^(DW-1), 2^(DW-1)-1], two's complement DW bits.
- out_img holds the last results until the next accepted start or rst.

Test Plan:
- Defaults, all pixels 1, filter0 all +1, filter1 all -1 (2'b11), relu_en=1: every out_img filter0 entry = 3 (acc 9, saturated) and every filter1 entry = 0. done rises exactly 100 edges after the start edge, and pix_valid is seen 100 times.
- Same stimulus with relu_en=0: filter0 entries = 1 (2'b01, clamped) and filter1 entries = 2'b10 (-2, clamped). busy is high for exactly 100 cycles.
- Random image, filter0 centre weight = 1 and all others 0, relu_en=1: out (r,c) = in (r+1,c+1) for all 100 positions. pix_row/pix_col follow the raster order (0,0),(0,1)...(9,9).
- Pulse start again at cycles 5 and 50 of a run, and change in_img mid-run: no restart, and results match the originally captured image. A start in the done cycle launches a second run with correct results.
- Assert rst at cycle 40 of a run: next cycle busy=0, out_img=0, pix_valid=0, and done never pulses. A fresh start then completes normally.
- Instance N=4, K=3, SHIFT=1, pixels all 3, weights all +1, relu_en=1: acc=27, s=13, so all 4 outputs = 3. done arrives 4 edges after start.
